alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised sequential ALU; next generation of the 4-bit tt_um_example datapath.
- Width is configurable. Operands enter through a valid/ready handshake and results leave through a second one.
- Adds an internal accumulator, status flags and an iterative multiplier.
- Sits between the ui_in/in_data input decode and the out_data output mux of the top-level tile.

Parameters:
- W, 8: operand/result width, 4..32.
- OPW, 4: opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ena  input  1  global enable; when 0, all state holds (stall).
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept an operation.
- op  input  OPW  opcode (alu_pkg encoding).
- a  input  W  operand A.
- b  input  W  operand B.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result.
- out_data  output  W  result.
- flags  output  4  {N, Z, C, V} of result.
- acc  output  W  current accumulator value.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; out_data=0; flags=0; acc=0; busy=0.
- Reset mid-operation aborts the operation; no result is produced.
- ena=0: FSM, registers, accumulator and multiplier all freeze. in_ready and out_valid hold their values, but no transfer occurs while ena=0.
- Accept: in_valid & in_ready & ena on a rising edge. Latch op, a and b; in_ready drops next cycle.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE -> EXEC on accept of a non-MUL op.
  - IDLE -> MUL on accept of MUL.
  - EXEC -> DONE after 1 cycle; result registered.
  - MUL -> DONE after W iterations.
  - DONE holds out_valid=1 and stable out_data/flags until out_ready & ena. It then returns to IDLE with in_ready=1 the next cycle.
- Latency, accept edge to out_valid high: 2 cycles for single-cycle ops, W+1 cycles for MUL. Throughput is one op per 3 cycles minimum; back-to-back acceptance is not supported.
- Ops (W-bit, wrap-around):
  - ADD: a+b; C=carry-out; V=signed overflow.
  - SUB: a-b; C=borrow (1 when a<b unsigned); V=signed overflow.
  - AND / OR / XOR / NOTA: C=0, V=0.
  - SHL: a<<b[log2W-1:0]; C=last bit shifted out (0 when shift=0).
  - SHR: logical right shift, same C rule.
  - MUL: unsigned shift-add over W cycles. out_data = low W bits; C = 1 if high W bits are nonzero; V=0.
  - ACCADD: acc <= acc + a; out_data = new acc; C/V as ADD.
  - ACCCLR: acc <= 0; out_data = 0.
  - PASSB: out_data = b.
  - Undefined opcode: out_data = 0, flags = 0, normal latency, no fault.
- Flags for every op: N = out_data[W-1]; Z = (out_data == 0).
- The accumulator changes only in the EXEC cycle of ACCADD/ACCCLR.
- Simultaneous in_valid while busy: ignored (in_ready=0); upstream must hold the request.
- out_ready asserted before out_valid has no effect.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOTA=5, SHL=6, SHR=7, MUL=8, ACCADD=9, ACCCLR=10, PASSB=11.
  - FSM state enum.
  - flag bit indices: N=3, Z=2, C=1, V=0.
- One sub-module: alu_mul_iter (W-parameterised shift-add multiplier with start/done and an ena hold). All other datapath logic stays inline.

Test Plan (W=8):
- Reset, then ADD a=0xF0, b=0x20 -> out_valid 2 cycles after accept; out_data=0x10; flags C=1, V=0, Z=0, N=0.
- SUB a=0x05, b=0x05, then SUB a=0x80, b=0x01 -> first: out_data=0x00, Z=1, C=0. Second: out_data=0x7F, V=1.
- MUL a=0x10, b=0x11 -> out_valid 9 cycles after accept; out_data=0x10; C=1. Drop ena for 3 cycles mid-MUL -> latency becomes 12 and the result is unchanged.
- ACCCLR, then ACCADD a=0x7F, then ACCADD a=0x01 -> acc=0x80, out_data=0x80, N=1, V=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay stable and in_ready=0. A new in_valid during this time is not accepted. Raise out_ready -> in_ready=1 the next cycle.
- Assert reset during MUL iteration 4 -> out_valid never rises; acc=0; in_ready=1 after release. A subsequent SHL a=0x81, b=1 -> out_data=0x02, C=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, FSM states, flag indices and shared helpers for alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] c_OP_ADD    = 4'd0;
  localparam logic [3:0] c_OP_SUB    = 4'd1;
  localparam logic [3:0] c_OP_AND    = 4'd2;
  localparam logic [3:0] c_OP_OR     = 4'd3;
  localparam logic [3:0] c_OP_XOR    = 4'd4;
  localparam logic [3:0] c_OP_NOTA   = 4'd5;
  localparam logic [3:0] c_OP_SHL    = 4'd6;
  localparam logic [3:0] c_OP_SHR    = 4'd7;
  localparam logic [3:0] c_OP_MUL    = 4'd8;
  localparam logic [3:0] c_OP_ACCADD = 4'd9;
  localparam logic [3:0] c_OP_ACCCLR = 4'd10;
  localparam logic [3:0] c_OP_PASSB  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int c_FLAG_N = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_C = 1;
  localparam int c_FLAG_V = 0;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic signed_ovf(input logic sa, input logic sb,
                                      input logic sr, input logic is_sub);
    if (is_sub) return (sa != sb) && (sr != sa);
    else        return (sa == sb) && (sr != sa);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Brief    : Unsigned shift-add multiplier, one partial product per enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           last,
  output logic [2*W-1:0] product
);

  localparam int c_CW = $clog2(W + 1);

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_prod;
  logic [c_CW-1:0] r_cnt;
  logic [2*W-1:0] w_step_prod;

  assign w_step_prod = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (ena) begin
      if (start) begin
        r_mcand  <= {{W{1'b0}}, a};
        r_mplier <= b;
        r_prod   <= '0;
        r_cnt    <= c_CW'(W);
      end else if (r_cnt != '0) begin
        r_prod   <= w_step_prod;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - c_CW'(1);
      end
    end
  end

  // The final partial product is exposed combinationally so the caller can
  // register it on the same edge as the last iteration.
  assign last    = (r_cnt == c_CW'(1));
  assign product = w_step_prod;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Sequential ALU with handshakes, accumulator, flags and iterative MUL.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [3:0]     flags,
  output logic [W-1:0]   acc,
  output logic           busy
);

  localparam int c_SHW = $clog2(W);

  state_t         r_state;
  state_t         w_state_next;
  logic [OPW-1:0] r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_out_data;
  logic [3:0]     r_flags;

  logic           w_accept;
  logic           w_is_mul;
  logic           w_mul_last;
  logic [2*W-1:0] w_mul_prod;
  logic [3:0]     w_mul_flags;

  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W:0]     w_acc_add;
  logic [c_SHW-1:0] w_sh;
  logic [2*W-1:0] w_shl;
  logic [2*W-1:0] w_shr;

  logic [W-1:0]   w_res;
  logic           w_c;
  logic           w_v;
  logic           w_known;
  logic [W-1:0]   w_acc_next;
  logic [3:0]     w_flags;

  assign w_accept = (r_state == ST_IDLE) && in_valid && ena;
  assign w_is_mul = (op == OPW'(c_OP_MUL));

  alu_mul_iter #(
    .W(W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .start   (w_accept && w_is_mul),
    .a       (a),
    .b       (b),
    .last    (w_mul_last),
    .product (w_mul_prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (ena) begin
      case (r_state)
        ST_IDLE: if (in_valid)   w_state_next = w_is_mul ? ST_MUL : ST_EXEC;
        ST_EXEC:                 w_state_next = ST_DONE;
        ST_MUL:  if (w_mul_last) w_state_next = ST_DONE;
        ST_DONE: if (out_ready)  w_state_next = ST_IDLE;
        default:                 w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_add     = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub     = {1'b0, r_a} - {1'b0, r_b};
  assign w_acc_add = {1'b0, r_acc} + {1'b0, r_a};
  assign w_sh      = r_b[c_SHW-1:0];
  // Widened shifts keep the last bit shifted out at a fixed position (bit W / W-1).
  assign w_shl     = {{W{1'b0}}, r_a} << w_sh;
  assign w_shr     = {r_a, {W{1'b0}}} >> w_sh;

  always_comb begin
    w_res      = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_known    = 1'b1;
    w_acc_next = r_acc;
    case (r_op)
      OPW'(c_OP_ADD): begin
        w_res = w_add[W-1:0];
        w_c   = w_add[W];
        w_v   = signed_ovf(r_a[W-1], r_b[W-1], w_add[W-1], 1'b0);
      end
      OPW'(c_OP_SUB): begin
        w_res = w_sub[W-1:0];
        w_c   = w_sub[W];
        w_v   = signed_ovf(r_a[W-1], r_b[W-1], w_sub[W-1], 1'b1);
      end
      OPW'(c_OP_AND):  w_res = r_a & r_b;
      OPW'(c_OP_OR):   w_res = r_a | r_b;
      OPW'(c_OP_XOR):  w_res = r_a ^ r_b;
      OPW'(c_OP_NOTA): w_res = ~r_a;
      OPW'(c_OP_SHL): begin
        w_res = w_shl[W-1:0];
        w_c   = w_shl[W];
      end
      OPW'(c_OP_SHR): begin
        w_res = w_shr[2*W-1:W];
        w_c   = w_shr[W-1];
      end
      OPW'(c_OP_ACCADD): begin
        w_res      = w_acc_add[W-1:0];
        w_c        = w_acc_add[W];
        w_v        = signed_ovf(r_acc[W-1], r_a[W-1], w_acc_add[W-1], 1'b0);
        w_acc_next = w_acc_add[W-1:0];
      end
      OPW'(c_OP_ACCCLR): w_acc_next = '0;
      OPW'(c_OP_PASSB):  w_res = r_b;
      default:           w_known = 1'b0;
    endcase
  end

  always_comb begin
    w_flags = '0;
    if (w_known) begin
      w_flags[c_FLAG_N] = w_res[W-1];
      w_flags[c_FLAG_Z] = (w_res == '0);
      w_flags[c_FLAG_C] = w_c;
      w_flags[c_FLAG_V] = w_v;
    end
  end

  always_comb begin
    w_mul_flags           = '0;
    w_mul_flags[c_FLAG_N] = w_mul_prod[W-1];
    w_mul_flags[c_FLAG_Z] = (w_mul_prod[W-1:0] == '0);
    w_mul_flags[c_FLAG_C] = |w_mul_prod[2*W-1:W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_flags    <= '0;
    end else if (ena) begin
      if (w_accept) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
      end
      if (r_state == ST_EXEC) begin
        r_out_data <= w_res;
        r_flags    <= w_flags;
        r_acc      <= w_acc_next;
      end
      if ((r_state == ST_MUL) && w_mul_last) begin
        r_out_data <= w_mul_prod[W-1:0];
        r_flags    <= w_mul_flags;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_out_data;
  assign flags     = r_flags;
  assign acc       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq at W=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W   = 8;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           ena;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [3:0]     flags;
  logic [W-1:0]   acc;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .W   (W),
    .OPW (OPW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flags     (flags),
    .acc       (acc),
    .busy      (busy)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency (cycle 1 = cycle after the accept edge),
  // check the result, optionally stall in DONE with a stray request, then drain.
  task automatic run_op(input string tag, input logic [3:0] o,
                        input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] exp_d, input logic [3:0] exp_f,
                        input int exp_lat, input bit drop, input int hold);
    int lat;
    @(negedge clk);
    chk_val($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (drop) ena = !(lat >= 3 && lat < 6);
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    chk_val($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
    chk_val($sformatf("%s_data", tag), 32'(out_data), 32'(exp_d));
    chk_val($sformatf("%s_flags", tag), 32'(flags), 32'(exp_f));
    if (hold > 0) begin
      op = c_OP_ACCADD; a = 8'h55; b = 8'h00; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk_val($sformatf("%s_hold_valid", tag), 32'(out_valid), 32'd1);
        chk_val($sformatf("%s_hold_data", tag), 32'(out_data), 32'(exp_d));
        chk_val($sformatf("%s_hold_ready", tag), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_val($sformatf("%s_drain_ready", tag), 32'(in_ready), 32'd1);
    chk_val($sformatf("%s_drain_valid", tag), 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_val("rst_in_ready", 32'(in_ready), 32'd1);
    chk_val("rst_out_valid", 32'(out_valid), 32'd0);
    chk_val("rst_out_data", 32'(out_data), 32'd0);
    chk_val("rst_flags", 32'(flags), 32'd0);
    chk_val("rst_acc", 32'(acc), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op("add",     c_OP_ADD,    8'hF0, 8'h20, 8'h10, 4'b0010, 2, 1'b0, 0);
    run_op("sub_eq",  c_OP_SUB,    8'h05, 8'h05, 8'h00, 4'b0100, 2, 1'b0, 0);
    run_op("sub_ovf", c_OP_SUB,    8'h80, 8'h01, 8'h7F, 4'b0001, 2, 1'b0, 0);
    run_op("sub_brw", c_OP_SUB,    8'h01, 8'h02, 8'hFF, 4'b1010, 2, 1'b0, 0);
    run_op("mul",     c_OP_MUL,    8'h10, 8'h11, 8'h10, 4'b0010, 9, 1'b0, 0);
    run_op("mul_ena", c_OP_MUL,    8'h10, 8'h11, 8'h10, 4'b0010, 12, 1'b1, 0);
    run_op("accclr",  c_OP_ACCCLR, 8'h00, 8'h00, 8'h00, 4'b0100, 2, 1'b0, 0);
    chk_val("acc_clr", 32'(acc), 32'h00);
    run_op("accadd1", c_OP_ACCADD, 8'h7F, 8'h00, 8'h7F, 4'b0000, 2, 1'b0, 0);
    run_op("accadd2", c_OP_ACCADD, 8'h01, 8'h00, 8'h80, 4'b1001, 2, 1'b0, 5);
    chk_val("acc_after_hold", 32'(acc), 32'h80);
    run_op("passb",   c_OP_PASSB,  8'h00, 8'hA5, 8'hA5, 4'b1000, 2, 1'b0, 0);
    run_op("xor",     c_OP_XOR,    8'hFF, 8'h0F, 8'hF0, 4'b1000, 2, 1'b0, 0);
    run_op("undef",   4'd15,       8'h00, 8'h00, 8'h00, 4'b0000, 2, 1'b0, 0);

    // Abort a multiply in its fourth iteration.
    @(negedge clk);
    op = c_OP_MUL; a = 8'h10; b = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk_val("abort_no_valid", 32'(seen), 32'd0);
    chk_val("abort_acc", 32'(acc), 32'h00);
    chk_val("abort_in_ready", 32'(in_ready), 32'd1);

    run_op("shl",     c_OP_SHL,    8'h81, 8'h01, 8'h02, 4'b0010, 2, 1'b0, 0);
    run_op("shl0",    c_OP_SHL,    8'h81, 8'h00, 8'h81, 4'b1000, 2, 1'b0, 0);
    run_op("shr",     c_OP_SHR,    8'h81, 8'h01, 8'h40, 4'b0010, 2, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
